// File: rtl/prog_loader.sv
// prog_loader: loads a length-prefixed stream of 18-bit words into program memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_loader #(
    parameter int MAX_WORDS = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [7:0]  BYTE_DATA,
    input  logic        BYTE_VALID,
    output logic        BYTE_READY,
    output logic        WR_EN,
    output logic [9:0]  WR_ADDR,
    output logic [17:0] WR_DATA,
    output logic        MCU_RST,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_B0,
        ST_B1,
        ST_B2,
        ST_WRITE,
`ifdef LOADER_CHECKSUM_EN
        ST_CHK,
`endif
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t ST_FIN = ST_CHK;
`else
    localparam state_t ST_FIN = ST_DONE;
`endif

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  len_hi_q;
    logic [15:0] len_q;
    logic [15:0] idx_q;
    logic [1:0]  b0_q;
    logic [7:0]  b1_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    logic        accept;
    logic        take_start;
    logic [15:0] n_full;
    logic [15:0] idx_inc;
    logic        ready_d;
    logic        wr_en_d;
    logic        busy_d;
    logic        mcu_rst_d;
    logic        done_d;
    logic        err_d;

    always_comb begin
        accept     = BYTE_VALID && BYTE_READY;
        take_start = 1'b0;
        n_full     = {len_hi_q, BYTE_DATA};
        idx_inc    = idx_q + 16'd1;
        state_d    = state_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (START) begin
                    state_d    = ST_LEN_HI;
                    take_start = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (accept) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (accept) begin
                    if (n_full == 16'd0)
                        state_d = ST_FIN;
                    else if (n_full > MAX_N)
                        state_d = ST_ERR;
                    else
                        state_d = ST_B0;
                end
            end
            ST_B0: begin
                if (accept) begin
                    if (BYTE_DATA[7:2] != 6'd0)
                        state_d = ST_ERR;
                    else
                        state_d = ST_B1;
                end
            end
            ST_B1: begin
                if (accept) state_d = ST_B2;
            end
            ST_B2: begin
                if (accept) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (idx_inc == len_q)
                    state_d = ST_FIN;
                else
                    state_d = ST_B0;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    if (BYTE_DATA == csum_q)
                        state_d = ST_DONE;
                    else
                        state_d = ST_ERR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered.
        ready_d   = 1'b0;
        wr_en_d   = 1'b0;
        busy_d    = 1'b1;
        mcu_rst_d = 1'b1;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_d)
            ST_IDLE: begin
                busy_d    = 1'b0;
                mcu_rst_d = 1'b0;
            end
            ST_DONE: begin
                busy_d    = 1'b0;
                mcu_rst_d = 1'b0;
                done_d    = 1'b1;
            end
            ST_ERR: begin
                busy_d = 1'b0;
                err_d  = 1'b1;
            end
            ST_WRITE: wr_en_d = 1'b1;
            default:  ready_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            BYTE_READY <= 1'b0;
            WR_EN      <= 1'b0;
            WR_ADDR    <= 10'd0;
            WR_DATA    <= 18'd0;
            MCU_RST    <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            len_hi_q   <= 8'd0;
            len_q      <= 16'd0;
            idx_q      <= 16'd0;
            b0_q       <= 2'd0;
            b1_q       <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            BYTE_READY <= ready_d;
            WR_EN      <= wr_en_d;
            MCU_RST    <= mcu_rst_d;
            BUSY       <= busy_d;
            DONE       <= done_d;
            ERR        <= err_d;

            if (take_start) begin
                idx_q   <= 16'd0;
                WR_ADDR <= 10'd0;
`ifdef LOADER_CHECKSUM_EN
                csum_q  <= 8'd0;
`endif
            end

            if (accept) begin
                case (state_q)
                    ST_LEN_HI: len_hi_q <= BYTE_DATA;
                    ST_LEN_LO: len_q    <= n_full;
                    ST_B0:     b0_q     <= BYTE_DATA[1:0];
                    ST_B1:     b1_q     <= BYTE_DATA;
                    ST_B2: begin
                        WR_DATA <= {b0_q, b1_q, BYTE_DATA};
                        WR_ADDR <= idx_q[9:0];
                    end
                    default: ;
                endcase
            end

            if (state_q == ST_WRITE) idx_q <= idx_inc;

`ifdef LOADER_CHECKSUM_EN
            if (accept && state_q != ST_CHK) csum_q <= csum_q ^ BYTE_DATA;
`endif
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: vector table, hand sequences and randomized loads
// checked against a stream-parsing reference model.
module tb_prog_loader;

    localparam int MAXW = 1024;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [7:0]  BYTE_DATA = 8'd0;
    logic        BYTE_VALID = 1'b0;
    logic        BYTE_READY;
    logic        WR_EN;
    logic [9:0]  WR_ADDR;
    logic [17:0] WR_DATA;
    logic        MCU_RST;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    prog_loader #(.MAX_WORDS(MAXW)) dut (
        .CLK(CLK),
        .RST(RST),
        .START(START),
        .BYTE_DATA(BYTE_DATA),
        .BYTE_VALID(BYTE_VALID),
        .BYTE_READY(BYTE_READY),
        .WR_EN(WR_EN),
        .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA),
        .MCU_RST(MCU_RST),
        .BUSY(BUSY),
        .DONE(DONE),
        .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;
    int ncyc = 0;

    always @(posedge CLK) ncyc <= ncyc + 1;

    logic [7:0]  stream[$];
    logic [27:0] obs[$];
    logic [27:0] exp_w[$];
    bit          exp_ok;

    always @(negedge CLK) if (WR_EN) obs.push_back({WR_ADDR, WR_DATA});

    typedef struct {
        string       nm;
        logic [95:0] bytes;
        int          nb;
        bit          ok;
        int          nw;
        logic [17:0] d0;
        logic [17:0] dl;
        logic [9:0]  la;
        int          max_lat;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_ready"}, BYTE_READY, 0);
        chk({p, "_wr_en"}, WR_EN, 0);
        chk({p, "_wr_addr"}, WR_ADDR, 0);
        chk({p, "_wr_data"}, WR_DATA, 0);
        chk({p, "_busy"}, BUSY, 0);
        chk({p, "_done"}, DONE, 0);
        chk({p, "_err"}, ERR, 0);
        chk({p, "_mcu_rst"}, MCU_RST, 0);
    endtask

    // Reference model: parse the stream as a loader would and list the writes.
    task automatic model();
        int n;
        int pos;
        logic [7:0] x;
        exp_w.delete();
        exp_ok = 1'b1;
        n = int'(stream[0]) * 256 + int'(stream[1]);
        pos = 2;
        if (n > MAXW) begin
            exp_ok = 1'b0;
        end else begin
            for (int w = 0; w < n; w++) begin
                if (stream[pos] > 8'd3) begin
                    exp_ok = 1'b0;
                    break;
                end
                exp_w.push_back({10'(w), 18'(int'(stream[pos]) * 65536 +
                                 int'(stream[pos + 1]) * 256 +
                                 int'(stream[pos + 2]))});
                pos += 3;
            end
        end
`ifdef LOADER_CHECKSUM_EN
        if (exp_ok) begin
            x = 8'd0;
            for (int i = 0; i < pos; i++) x ^= stream[i];
            exp_ok = (stream[pos] == x);
        end
`else
        x = 8'd0;
`endif
    endtask

    task automatic gen(input int n, input int bad_at, input bit bad_sum);
        logic [17:0] d;
        logic [7:0]  x;
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        if (n <= MAXW) begin
            for (int w = 0; w < n; w++) begin
                d = 18'($urandom);
                stream.push_back(w == bad_at ? 8'($urandom_range(255, 4))
                                             : {6'd0, d[17:16]});
                stream.push_back(d[15:8]);
                stream.push_back(d[7:0]);
            end
        end
        x = 8'd0;
        foreach (stream[i]) x ^= stream[i];
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(bad_sum ? ~x : x);
`else
        if (bad_sum) x = ~x;
`endif
    endtask

    task automatic feed(input int gap, input int start_at, input int rst_at,
                        output int lat);
        int idx = 0;
        int k = 0;
        int acc_edge = 0;
        int budget;
        bit want;
        budget = 40 * stream.size() + 200;
        lat = 0;
        while (idx < stream.size() && !(DONE || ERR)) begin
            if (k >= budget) begin
                n_chk++;
                n_fail++;
                $display("FAIL feed_timeout: got %0d of %0d bytes accepted",
                         idx, stream.size());
                break;
            end
            want = ($urandom_range(99) >= gap);
            BYTE_VALID = want;
            BYTE_DATA = want ? stream[idx] : 8'($urandom);
            START = (k == start_at);
            if (want && BYTE_READY) begin
                idx++;
                acc_edge = ncyc + 1;
            end
            @(negedge CLK);
            k++;
            if (rst_at >= 0 && WR_EN && WR_ADDR == 10'(rst_at)) begin
                #2 RST = 1'b1;
                BYTE_VALID = 1'b0;
                START = 1'b0;
                #1 chk_reset("midrst");
                return;
            end
        end
        BYTE_VALID = 1'b0;
        START = 1'b0;
        k = 0;
        while (!(DONE || ERR) && k < 50) begin
            @(negedge CLK);
            k++;
        end
        chk("complete", DONE | ERR, 1);
        lat = ncyc - acc_edge + 1;
    endtask

    task automatic run_load(input int gap, input int start_at,
                            input int rst_at, output int lat);
        obs.delete();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("start_busy", BUSY, 1);
        chk("start_mcu_rst", MCU_RST, 1);
        chk("start_ready", BYTE_READY, 1);
        chk("start_flags_clr", {DONE, ERR}, 0);
        feed(gap, start_at, rst_at, lat);
    endtask

    task automatic check_result();
        chk("wr_count", obs.size(), exp_w.size());
        for (int i = 0; i < obs.size() && i < exp_w.size(); i++)
            chk($sformatf("wr[%0d]", i), obs[i], exp_w[i]);
        chk("done", DONE, exp_ok);
        chk("err", ERR, !exp_ok);
        chk("mcu_rst", MCU_RST, !exp_ok);
        chk("busy_end", BUSY, 0);
        chk("ready_end", BYTE_READY, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int mode;
        int bad_at;

`ifdef LOADER_CHECKSUM_EN
        vt.push_back('{"sum_ok", 96'h00_0100_0007_06, 6, 1'b1, 1,
                       18'h00007, 18'h00007, 10'd0, 1});
        vt.push_back('{"sum_bad", 96'h00_0100_0007_07, 6, 1'b0, 1,
                       18'h00007, 18'h00007, 10'd0, 1});
        vt.push_back('{"sum_n0", 96'h00_0000, 3, 1'b1, 0,
                       18'h0, 18'h0, 10'd0, 1});
        vt.push_back('{"len_over", 96'h0401, 2, 1'b0, 0,
                       18'h0, 18'h0, 10'd0, 1});
`else
        vt.push_back('{"two_words", 96'h0002_0123_4502_ABCD, 8, 1'b1, 2,
                       18'h12345, 18'h2ABCD, 10'd1, 2});
        vt.push_back('{"bad_b0", 96'h00_0104_0000, 5, 1'b0, 0,
                       18'h0, 18'h0, 10'd0, 1});
        vt.push_back('{"len_over", 96'h0401, 2, 1'b0, 0,
                       18'h0, 18'h0, 10'd0, 1});
        vt.push_back('{"len_ffff", 96'hFFFF, 2, 1'b0, 0,
                       18'h0, 18'h0, 10'd0, 1});
        vt.push_back('{"n_zero", 96'h0000, 2, 1'b1, 0,
                       18'h0, 18'h0, 10'd0, 1});
        vt.push_back('{"max_word", 96'h00_0103_FFFF, 5, 1'b1, 1,
                       18'h3FFFF, 18'h3FFFF, 10'd0, 2});
        vt.push_back('{"bad_w1", 96'h0002_0000_01FF_0000, 8, 1'b0, 1,
                       18'h00001, 18'h00001, 10'd0, 1});
`endif

        repeat (3) @(negedge CLK);
        chk_reset("por");
        #1 RST = 1'b0;

        foreach (vt[i]) begin
            stream.delete();
            for (int j = 0; j < vt[i].nb; j++)
                stream.push_back(8'(vt[i].bytes >> (8 * (vt[i].nb - 1 - j))));
            run_load(0, -1, -1, lat);
            chk({vt[i].nm, "_done"}, DONE, vt[i].ok);
            chk({vt[i].nm, "_err"}, ERR, !vt[i].ok);
            chk({vt[i].nm, "_mcu_rst"}, MCU_RST, !vt[i].ok);
            chk({vt[i].nm, "_ready"}, BYTE_READY, 0);
            chk({vt[i].nm, "_nw"}, obs.size(), vt[i].nw);
            if (obs.size() > 0 && vt[i].nw > 0) begin
                chk({vt[i].nm, "_first"}, obs[0], {10'd0, vt[i].d0});
                chk({vt[i].nm, "_last"}, obs[obs.size() - 1],
                    {vt[i].la, vt[i].dl});
                chk({vt[i].nm, "_wr_addr_hold"}, WR_ADDR, vt[i].la);
            end
            chk({vt[i].nm, "_latency_ok"}, lat <= vt[i].max_lat, 1);
        end

        // START pulsed while a load is running must be ignored.
        gen(6, -1, 1'b0);
        model();
        run_load(0, 7, -1, lat);
        check_result();

        // Reset in the middle of a write, then a clean reload.
        gen(10, -1, 1'b0);
        model();
        run_load(0, -1, 5, lat);
        @(negedge CLK);
        chk_reset("rst_hold");
        #1 RST = 1'b0;
        run_load(20, -1, -1, lat);
        check_result();

        // Full-size load with random valid gaps.
        gen(MAXW, -1, 1'b0);
        model();
        run_load(30, -1, -1, lat);
        check_result();
        chk("last_wr_addr", WR_ADDR, MAXW - 1);

        for (int r = 0; r < 10; r++) begin
            mode = $urandom_range(5);
            bad_at = -1;
            if (mode == 0) begin
                n = MAXW + 1 + $urandom_range(2000);
            end else if (mode == 1) begin
                n = $urandom_range(16, 1);
                bad_at = $urandom_range(n - 1);
            end else begin
                n = $urandom_range(16);
            end
            gen(n, bad_at, mode == 2);
            model();
            run_load($urandom_range(60), -1, -1, lat);
            check_result();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter MAX_WORDS, default 1024, is the largest accepted program length in 18-bit words.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, asynchronous and active-high.
REQ-004 START  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
REQ-005 BYTE_DATA  in  8  incoming stream byte (e.g. from UART receiver).
REQ-006 BYTE_VALID  in  1  BYTE_DATA valid.
REQ-007 BYTE_READY  out  1  loader accepts a byte; transfer occurs when BYTE_VALID and BYTE_READY are both high at a clock edge.
REQ-008 WR_EN  out  1  one-cycle write strobe to the 1024x18 program memory.
REQ-009 WR_ADDR  out  10  program memory write address.
REQ-010 WR_DATA  out  18  instruction word to write.
REQ-011 MCU_RST  out  1  holds the RAT MCU in reset while a load is in progress or has failed.
REQ-012 BUSY  out  1  load in progress.
REQ-013 DONE  out  1  last load completed successfully (level).
REQ-014 ERR  out  1  last load aborted (level).

Function
REQ-015 States SHALL be IDLE, LEN_HI, LEN_LO, B0, B1, B2, WRITE, (CHK when configured), DONE, ERR.
REQ-016 Stream format: 2-byte big-endian word count N, then N words of 3 bytes each, big-endian, word = {B0[1:0], B1, B2}.
REQ-017 IDLE/DONE/ERR + START -> LEN_HI; word counter, write address and checksum cleared to 0 on that edge.
REQ-018 BYTE_READY SHALL be high only in LEN_HI, LEN_LO, B0, B1, B2, CHK; each accepted byte advances exactly one state.
REQ-019 BYTE_VALID without BYTE_READY SHALL be ignored; loader never drops or duplicates an accepted byte.
REQ-020 After LEN_LO: N = 0 -> DONE (or CHK); N > MAX_WORDS -> ERR; else -> B0.
REQ-021 Accepted B0 with BYTE_DATA[7:2] != 0 -> ERR, no write issued.
REQ-022 After B2 -> WRITE for exactly one cycle: WR_EN = 1, WR_ADDR = word index, WR_DATA = assembled word; BYTE_READY = 0.
REQ-023 WRITE: word index +1; if new index == N -> DONE (or CHK), else -> B0.
REQ-024 WR_ADDR SHALL hold its last value outside WRITE; WR_DATA SHALL change only on B2 acceptance.
REQ-025 Throughput: one word per 4 cycles minimum with BYTE_VALID held high.
REQ-026 BUSY = 1 in all states except IDLE, DONE, ERR.
REQ-027 MCU_RST = 1 in all states except IDLE and DONE.
REQ-028 DONE = 1 only in DONE; ERR = 1 only in ERR; both cleared on the edge that accepts START.
REQ-029 START while BUSY SHALL be ignored.
REQ-030 All outputs SHALL be registered (no combinational path input -> output except none).

Reset
REQ-031 RST asserted at any time, including mid-load, SHALL immediately force IDLE, BYTE_READY=0, WR_EN=0, WR_ADDR=0, WR_DATA=0, BUSY=0, DONE=0, ERR=0, MCU_RST=0, counters and checksum 0.
REQ-032 A write in progress when RST asserts SHALL be suppressed (WR_EN low asynchronously).

Configuration
REQ-033 Macro LOADER_CHECKSUM_EN defined: one trailing byte accepted in CHK after the last word (or after LEN_LO when N=0); equal to XOR of all preceding stream bytes including length -> DONE, else -> ERR.
REQ-034 LOADER_CHECKSUM_EN undefined: CHK state absent; completion goes directly to DONE; no checksum logic synthesized.

Verification
REQ-035 RST, START, stream 00 02 | 01 23 45 | 02 AB CD, VALID held -> writes 0x12345 @0, 0x2ABCD @1, DONE=1, MCU_RST=0, 8 cycles after last byte at most 2.
REQ-036 Stream 00 01 | 04 00 00 -> ERR=1, MCU_RST=1, WR_EN never asserted.
REQ-037 Stream 04 01 (N=1025, MAX_WORDS=1024) -> ERR after second byte, BYTE_READY=0.
REQ-038 Random BYTE_VALID gaps on a 1024-word load -> every address 0..1023 written once, data matches, last WR_ADDR=1023.
REQ-039 RST pulse after 5 words of a 10-word load -> all outputs at reset values same cycle; new START + full stream succeeds.
REQ-040 With LOADER_CHECKSUM_EN: 00 01 00 00 07 checksum 06 -> DONE; checksum 07 -> ERR.
